prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Writer-side companion to the processor's instruction/data RAM.
- Accepts a program image as a stream of 16-bit words from a host or testbench and writes the words to consecutive RAM addresses starting at 0.
- Holds the processor in reset for the whole load, then releases it so execution starts from a fully written memory.
- Replaces the hand-sequenced w/rst/clk stimulus used to bring the processor up.

Parameters:
- AW, 5, RAM address width; RAM depth is 2**AW words.
- DW, 16, RAM word width; matches the processor register width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; sampled in IDLE and RUN only.
- length  in  AW+1  number of words to load; sampled on start; values above 2**AW are clamped to 2**AW.
- in_data  in  DW  stream word.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a word; a transfer occurs when in_valid && in_ready.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  DW  RAM write data.
- ram_w  out  1  RAM write enable, one cycle per word.
- ram_rdata  in  DW  RAM read data, 1-cycle synchronous latency; used only with LOADER_VERIFY_EN.
- proc_rst  out  1  processor reset; active-high.
- busy  out  1  loader is in LOAD or VERIFY.
- done  out  1  high while in RUN.
- error  out  1  readback checksum mismatch; sticky until the next start or rst.
- word_count  out  AW+1  number of words accepted in the current load.

Behaviour:
- Reset values (rst=1 at the clock edge; takes priority over everything, including mid-load):
  - State IDLE.
  - in_ready=0, ram_w=0, ram_addr=0, ram_wdata=0.
  - proc_rst=1, busy=0, done=0, error=0, word_count=0, checksum=0.
- IDLE:
  - proc_rst=1.
  - start with clamped length N>0 -> LOAD. Clears word_count, checksum and error.
  - start with N=0 -> RUN directly.
- LOAD:
  - in_ready=1 while word_count<N; busy=1; proc_rst=1.
  - On a transfer: next cycle ram_w=1, ram_addr=word_count (pre-increment value), ram_wdata=in_data. Fixed 1-cycle input-to-write latency.
  - Also on a transfer: word_count increments and checksum += in_data (mod 2**DW).
  - in_valid without in_ready, or in_ready without in_valid: no write, no count change.
  - The last transfer (word_count reaches N) drops in_ready on the following cycle. After that last write (ram_w high), the state moves to RUN, or to VERIFY when the feature is enabled.
  - No back-pressure from RAM; one word per cycle is sustainable.
- RUN:
  - proc_rst=0 from the first RUN cycle; done=1; in_ready=0; ram_w=0.
  - start in RUN -> LOAD next cycle. proc_rst returns to 1 in that same cycle, done=0.
- start while in LOAD or VERIFY is ignored.
- Addresses never wrap, because of the clamp. N=2**AW writes addresses 0 .. 2**AW-1 exactly once.
- Reset mid-load: the loader returns to IDLE. Partially written RAM contents are left as-is; the loader does not clear memory.

Optional Feature:
- Macro LOADER_VERIFY_EN.
- With the macro defined, VERIFY state after LOAD:
  - ram_addr steps 0..N-1, one per cycle, with ram_w=0.
  - ram_rdata is summed one cycle after each address (mod 2**DW).
  - After the last sample, the readback sum is compared with the load checksum. Mismatch -> error=1. Either way the state then moves to RUN.
  - proc_rst stays 1 and busy stays 1 throughout VERIFY.
  - VERIFY takes N+1 cycles.
- Without the macro: no VERIFY state, ram_rdata is unused, error is tied to 0.

Decomposition:
- Shared package (prog_loader_pkg):
  - State encoding constants: IDLE, LOAD, VERIFY, RUN.
  - Default AW/DW widths, shared with the processor/RAM.
- One natural sub-module: loader_checksum. A DW-wide accumulator with clear and add-enable, instantiated twice (load sum, readback sum) when LOADER_VERIFY_EN is defined.

Test Plan:
- Basic load:
  - Stimulus: rst 2 cycles; start with length=4; stream 0x1111, 0x2222, 0x3333, 0x4444 back-to-back.
  - Response: ram_w pulses at addr 0..3 with matching data, each 1 cycle after its transfer; proc_rst falls the cycle after the last write; done=1.
- Back-pressure gaps:
  - Stimulus: length=3 with in_valid low for 2 cycles between words.
  - Response: exactly 3 writes at addr 0,1,2; word_count=3; no spurious ram_w.
- Length edge cases:
  - Stimulus: length=0.
  - Response: RUN the cycle after start, with no writes.
  - Stimulus: length=40 with AW=5.
  - Response: clamped to 32 writes, addr 0..31; in_ready low after the 32nd transfer.
- Reset mid-load:
  - Stimulus: rst asserted after 2 of 5 words.
  - Response: IDLE, proc_rst=1, word_count=0, in_ready=0.
  - Stimulus: new start with length=2.
  - Response: writes begin again at addr 0.
- Restart from RUN:
  - Stimulus: start in RUN.
  - Response: proc_rst=1 and done=0 the next cycle; reload overwrites from addr 0.
- Verify (LOADER_VERIFY_EN):
  - Stimulus: load 0x0001, 0x0002 with a model RAM.
  - Response: error=0, RUN reached after N+1 VERIFY cycles.
  - Stimulus: corrupt the model word at addr 1 before VERIFY.
  - Response: error=1 and RUN is still entered.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: state encoding and the default
// address/data widths used by the processor and its instruction/data RAM.
package prog_loader_pkg;

    localparam int unsigned AW_DEFAULT = 5;
    localparam int unsigned DW_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_RUN    = 2'd3
    } state_e;

endpackage

// File: rtl/prog_loader_if.sv
// Host stream, RAM write/read port and processor control bundled for the loader.
// The slave modport is the loader's view; the master modport is the host/RAM side.
interface prog_loader_if
    import prog_loader_pkg::*;
#(
    parameter int unsigned AW = AW_DEFAULT,
    parameter int unsigned DW = DW_DEFAULT
);
    logic          start;
    logic [AW:0]   length;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_w;
    logic [DW-1:0] ram_rdata;
    logic          proc_rst;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   word_count;

    modport slave (
        input  start, length, in_data, in_valid, ram_rdata,
        output in_ready, ram_addr, ram_wdata, ram_w, proc_rst, busy, done, error, word_count
    );

    modport master (
        output start, length, in_data, in_valid, ram_rdata,
        input  in_ready, ram_addr, ram_wdata, ram_w, proc_rst, busy, done, error, word_count
    );
endinterface

// File: rtl/loader_checksum.sv
// DW-wide modular accumulator with synchronous clear and add-enable; clear wins.
module loader_checksum
    import prog_loader_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          add_en,
    input  logic [DW-1:0] add_val,
    output logic [DW-1:0] sum
);
    logic [DW-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = '0;
        end else if (add_en) begin
            sum_d = sum_q + add_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;
endmodule

// File: rtl/prog_loader.sv
// Streams a program image into RAM from address 0 while holding the processor in reset.
// Define LOADER_VERIFY_EN to add a readback-checksum VERIFY pass before release.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned AW = AW_DEFAULT,
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    prog_loader_if.slave  bus
);
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    state_e        state_q, state_d;
    logic [AW:0]   n_q, n_d;
    logic [AW:0]   word_count_q, word_count_d;
    logic          ram_w_q, ram_w_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    logic          error_q, error_d;

    logic [AW:0]   n_clamp;
    logic          in_ready;
    logic          xfer;
    logic          sum_clr;
    logic [DW-1:0] load_sum;

    // Clamping here is what keeps addresses from ever wrapping.
    assign n_clamp = (bus.length > DEPTH) ? DEPTH : bus.length;

    loader_checksum #(.DW(DW)) u_load_sum (
        .clk(clk), .rst(rst), .clr(sum_clr), .add_en(xfer), .add_val(bus.in_data), .sum(load_sum)
    );

`ifdef LOADER_VERIFY_EN
    logic [AW:0]   vcnt_q, vcnt_d;
    logic          rb_clr, rb_add;
    logic [DW-1:0] rb_sum, rb_final;

    loader_checksum #(.DW(DW)) u_rb_sum (
        .clk(clk), .rst(rst), .clr(rb_clr), .add_en(rb_add), .add_val(bus.ram_rdata), .sum(rb_sum)
    );

    // Includes the final sample arriving in the last VERIFY cycle.
    assign rb_final = rb_sum + bus.ram_rdata;
`else
    logic unused_verify;
    assign unused_verify = ^{load_sum, bus.ram_rdata};
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_d      = state_q;
        n_d          = n_q;
        word_count_d = word_count_q;
        ram_w_d      = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        error_d      = error_q;
        sum_clr      = 1'b0;
        in_ready     = (state_q == ST_LOAD) && (word_count_q < n_q);
        xfer         = in_ready && bus.in_valid;
`ifdef LOADER_VERIFY_EN
        vcnt_d       = vcnt_q;
        rb_clr       = 1'b0;
        rb_add       = 1'b0;
`endif

        unique case (state_q)
            ST_IDLE, ST_RUN: begin
                if (bus.start) begin
                    n_d          = n_clamp;
                    word_count_d = '0;
                    error_d      = 1'b0;
                    sum_clr      = 1'b1;
                    state_d      = (n_clamp != '0) ? ST_LOAD : ST_RUN;
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    ram_w_d      = 1'b1;
                    ram_addr_d   = word_count_q[AW-1:0];
                    ram_wdata_d  = bus.in_data;
                    word_count_d = word_count_q + 1'b1;
                end
                // Leave only once the final word's write pulse is on the bus.
                if (ram_w_q && (word_count_q == n_q)) begin
`ifdef LOADER_VERIFY_EN
                    state_d    = ST_VERIFY;
                    ram_addr_d = '0;
                    vcnt_d     = '0;
                    rb_clr     = 1'b1;
`else
                    state_d    = ST_RUN;
`endif
                end
            end
            ST_VERIFY: begin
`ifdef LOADER_VERIFY_EN
                rb_add = (vcnt_q != '0);
                if (vcnt_q == n_q) begin
                    error_d = (rb_final != load_sum);
                    state_d = ST_RUN;
                end else begin
                    vcnt_d = vcnt_q + 1'b1;
                    if ((vcnt_q + 1'b1) < n_q) begin
                        ram_addr_d = ram_addr_q + 1'b1;
                    end
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q      <= ST_IDLE;
            n_q          <= '0;
            word_count_q <= '0;
            ram_w_q      <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            word_count_q <= word_count_d;
            ram_w_q      <= ram_w_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            error_q      <= error_d;
        end
    end

`ifdef LOADER_VERIFY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            vcnt_q <= '0;
        end else begin
            vcnt_q <= vcnt_d;
        end
    end
    assign bus.error = error_q;
`else
    logic unused_error;
    assign unused_error = error_q;
    assign bus.error    = 1'b0;
`endif

    assign bus.in_ready   = in_ready;
    assign bus.ram_w      = ram_w_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = ram_wdata_q;
    assign bus.word_count = word_count_q;
    assign bus.proc_rst   = (state_q != ST_RUN);
    assign bus.busy       = (state_q == ST_LOAD) || (state_q == ST_VERIFY);
    assign bus.done       = (state_q == ST_RUN);
endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader: a transaction/timeline model
// predicts every output each cycle, plus literal checks on RAM contents and counts.
module tb_prog_loader;
    localparam int AW = 5;
    localparam int DW = 16;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic corrupt = 1'b0;

    prog_loader_if #(.AW(AW), .DW(DW)) bus ();

    prog_loader #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;
    int wr_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model RAM with 1-cycle read latency; 'corrupt' flips bits of word 1.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.ram_w) mem[bus.ram_addr] <= bus.ram_wdata;
        else if (corrupt) mem[1] <= mem[1] ^ 16'h00F0;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

`ifdef LOADER_VERIFY_EN
    function automatic logic [DW-1:0] ram_sum(input int n);
        logic [DW-1:0] s = '0;
        for (int i = 0; i < n; i++) s += mem[i];
        return s;
    endfunction
`endif

    // ---------------- behavioural timeline model + per-cycle compare ----------------
    typedef struct { int due; int addr; logic [DW-1:0] data; } wr_t;
    wr_t wq[$];
    int  cyc = 0;
    bit  m_loading = 0, m_running = 0, m_err = 0;
    int  m_n = 0, m_cnt = 0, m_run_at = -1;
    logic [DW-1:0] m_sum = '0;

    initial begin : model_and_compare
        bit accept, exp_w;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_loading = 0; m_running = 0; m_err = 0;
                m_n = 0; m_cnt = 0; m_sum = '0; m_run_at = -1;
                wq.delete();
            end else begin
                accept = bus.start && !m_loading;
                if (m_loading && m_cnt < m_n && bus.in_valid) begin
                    wq.push_back('{due: cyc, addr: m_cnt, data: bus.in_data});
                    m_cnt++;
                    m_sum += bus.in_data;
                    if (m_cnt == m_n) begin
                        m_run_at = cyc + 1;
`ifdef LOADER_VERIFY_EN
                        m_run_at += m_n + 1;
`endif
                    end
                end
                if (m_loading && cyc == m_run_at) begin
                    m_loading = 0;
                    m_running = 1;
`ifdef LOADER_VERIFY_EN
                    m_err = (ram_sum(m_n) != m_sum);
`endif
                end
                if (accept) begin
                    m_n = (int'(bus.length) > DEPTH) ? DEPTH : int'(bus.length);
                    m_cnt = 0; m_sum = '0; m_err = 0;
                    m_loading = (m_n != 0);
                    m_running = (m_n == 0);
                    m_run_at = -1;
                end
            end
            @(negedge clk);
            exp_w = (wq.size() > 0) && (wq[0].due == cyc);
            check("in_ready", bus.in_ready, m_loading && (m_cnt < m_n));
            check("ram_w", bus.ram_w, exp_w);
            if (exp_w) begin
                check("ram_addr", bus.ram_addr, wq[0].addr);
                check("ram_wdata", bus.ram_wdata, wq[0].data);
                void'(wq.pop_front());
            end
            check("proc_rst", bus.proc_rst, !m_running);
            check("done", bus.done, m_running);
            check("busy", bus.busy, m_loading);
            check("error", bus.error, m_err);
            check("word_count", bus.word_count, m_cnt);
            if (bus.ram_w) wr_seen++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int k);
        rst = 1'b1;
        repeat (k) tick();
        rst = 1'b0;
    endtask

    task automatic do_start(input int len);
        bus.start = 1'b1;
        bus.length = (AW+1)'(len);
        tick();
        bus.start = 1'b0;
    endtask

    // Gap cycles carry occasional stray start pulses, which LOAD must ignore.
    task automatic send_word(input logic [DW-1:0] d, input int gap);
        bit acc = 0;
        for (int g = 0; g < gap; g++) begin
            if ($urandom_range(0, 7) == 0) begin
                bus.start = 1'b1;
                bus.length = (AW+1)'($urandom_range(0, 40));
            end
            tick();
            bus.start = 1'b0;
        end
        bus.in_valid = 1'b1;
        bus.in_data = d;
        for (int k = 0; k < 64 && !acc; k++) begin
            acc = bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        check("word_accepted", acc, 1'b1);
    endtask

    task automatic offer(input logic [DW-1:0] d, input int cycles);
        bus.in_valid = 1'b1;
        bus.in_data = d;
        repeat (cycles) tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_run(input int budget);
        for (int k = 0; k < budget && !bus.done; k++) tick();
        check("run_reached", bus.done, 1'b1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin : stimulus
        logic [DW-1:0] sent [DEPTH];
        int w0, len, nw, cut;
        bus.start = 0; bus.length = '0; bus.in_data = '0; bus.in_valid = 0;

        do_reset(2);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_ram_w", bus.ram_w, 0);
        check("rst_ram_addr", bus.ram_addr, 0);
        check("rst_ram_wdata", bus.ram_wdata, 0);
        check("rst_proc_rst", bus.proc_rst, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_error", bus.error, 0);
        check("rst_word_count", bus.word_count, 0);

        // Basic load, back-to-back
        w0 = wr_seen;
        do_start(4);
        send_word(16'h1111, 0); send_word(16'h2222, 0);
        send_word(16'h3333, 0); send_word(16'h4444, 0);
        wait_run(20);
        check("basic_writes", wr_seen - w0, 4);
        check("basic_mem0", mem[0], 16'h1111);
        check("basic_mem3", mem[3], 16'h4444);
        check("basic_proc_rst", bus.proc_rst, 0);

        // Gaps between words
        w0 = wr_seen;
        do_start(3);
        send_word(16'hA001, 2); send_word(16'hA002, 2); send_word(16'hA003, 2);
        wait_run(20);
        check("gap_writes", wr_seen - w0, 3);
        check("gap_word_count", bus.word_count, 3);
        check("gap_mem2", mem[2], 16'hA003);

        // Zero length from IDLE
        do_reset(1);
        w0 = wr_seen;
        do_start(0);
        check("len0_done", bus.done, 1);
        tick();
        check("len0_writes", wr_seen - w0, 0);

        // Clamp 40 -> 32, extra word must be refused
        w0 = wr_seen;
        do_start(40);
        for (int i = 0; i < DEPTH; i++) begin
            sent[i] = DW'($urandom);
            send_word(sent[i], $urandom_range(0, 1));
        end
        check("clamp_ready_low", bus.in_ready, 0);
        offer(16'hDEAD, 4);
        wait_run(80);
        check("clamp_writes", wr_seen - w0, 32);
        check("clamp_word_count", bus.word_count, 32);
        check("clamp_mem0", mem[0], sent[0]);
        check("clamp_mem31", mem[31], sent[31]);

        // Reset mid-load, then reload from address 0
        do_start(5);
        send_word(16'hC001, 0); send_word(16'hC002, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        check("midrst_proc_rst", bus.proc_rst, 1);
        check("midrst_word_count", bus.word_count, 0);
        check("midrst_in_ready", bus.in_ready, 0);
        do_start(2);
        send_word(16'hAAAA, 0); send_word(16'hBBBB, 1);
        wait_run(20);
        check("reload_mem0", mem[0], 16'hAAAA);
        check("reload_mem1", mem[1], 16'hBBBB);

        // Restart from RUN
        do_start(3);
        check("restart_proc_rst", bus.proc_rst, 1);
        check("restart_done", bus.done, 0);
        send_word(16'h5A5A, 0); send_word(16'h6B6B, 0); send_word(16'h7C7C, 0);
        wait_run(20);
        check("restart_mem0", mem[0], 16'h5A5A);

        // Randomized loads with optional mid-load reset and idle noise
        for (int it = 0; it < 14; it++) begin
            len = $urandom_range(0, 40);
            nw = (len > DEPTH) ? DEPTH : len;
            cut = ($urandom_range(0, 5) == 0 && nw > 0) ? $urandom_range(0, nw - 1) : -1;
            do_start(len);
            for (int i = 0; i < nw; i++) begin
                if (i == cut) begin
                    rst = 1'b1; tick(); rst = 1'b0;
                    break;
                end
                send_word(DW'($urandom), $urandom_range(0, 2));
            end
            if (cut < 0) begin
                wait_run(100);
                offer(DW'($urandom), $urandom_range(0, 3));
            end
        end

`ifdef LOADER_VERIFY_EN
        do_start(2);
        send_word(16'h0001, 0); send_word(16'h0002, 0);
        wait_run(20);
        check("verify_ok_error", bus.error, 0);
        do_start(2);
        send_word(16'h0001, 0); send_word(16'h0002, 0);
        tick();
        corrupt = 1'b1; tick(); corrupt = 1'b0;
        wait_run(20);
        check("verify_bad_error", bus.error, 1);
        check("verify_bad_done", bus.done, 1);
`endif

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
